// File: rtl/gcm_aes_arbiter_pkg.sv
// Shared GCM definitions: requester indices, arbiter state encoding and the AES block type.
package gcm_pkg;

    localparam int REQ_HGEN    = 0;
    localparam int REQ_TAGMASK = 1;
    localparam int REQ_CTR     = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef logic [127:0] block_t;

endpackage

// File: rtl/gcm_aes_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_valid
);

    localparam int IW = $clog2(N_REQ);

    always_comb begin
        int c;
        c           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (!grant_valid && req[c]) begin
                grant[c]    = 1'b1;
                grant_idx   = IW'(c);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcm_aes_arbiter.sv
// Shares one AES-128 core among the GCM helpers: round-robin grant, single job in flight,
// result routed back as a one-cycle pulse, watchdog-bounded wait on the core.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no job; grant the next requester when the core is ready
//   ST_ISSUE | aes_start pulsed with the latched block; arm watchdog
//   ST_WAIT  | waiting for aes_result_valid or watchdog terminal count
module gcm_aes_arbiter
    import gcm_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*128-1:0]     req_block,
    output logic [N_REQ-1:0]         ack,
    output logic [127:0]             resp_data,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic                     aes_ready,
    output logic                     aes_start,
    output logic [127:0]             aes_block,
    input  logic [127:0]             aes_result,
    input  logic                     aes_result_valid,
    input  logic                     flush,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    logic [1:0]       state_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [WW-1:0]    wd_q;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             grant_fire;
    logic [IW-1:0]    next_ptr;
    block_t           sel_block;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req         (req),
        .rr_ptr      (rr_ptr_q),
        .grant       (pick_onehot),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // rst_n gates ack so outputs read as reset values while reset is held
    assign grant_fire = rst_n && (state_q == ST_IDLE) && pick_valid && aes_ready && !flush;
    assign ack        = grant_fire ? pick_onehot : '0;
    assign busy       = (state_q != ST_IDLE);
    assign sel_block  = req_block[128*pick_idx +: 128];
    assign next_ptr   = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    // Watchdog is a down-counter: loaded in ISSUE, terminal count at zero
    // corresponds to the TIMEOUT_CYCLES-th WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            wd_q        <= '0;
            resp_data   <= '0;
            resp_valid  <= '0;
            aes_start   <= 1'b0;
            aes_block   <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            resp_valid <= '0;
            aes_start  <= 1'b0;
            if (flush) begin
                state_q     <= ST_IDLE;
                wd_q        <= '0;
                timeout_err <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (grant_fire) begin
                            state_q   <= ST_ISSUE;
                            grant_id  <= pick_idx;
                            aes_block <= sel_block;
                            aes_start <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        state_q <= ST_WAIT;
                        wd_q    <= WD_LOAD;
                    end
                    ST_WAIT: begin
                        if (aes_result_valid) begin
                            resp_data  <= aes_result;
                            resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                            rr_ptr_q   <= next_ptr;
                            state_q    <= ST_IDLE;
                        end else if (wd_q == '0) begin
                            timeout_err <= 1'b1;
                            rr_ptr_q    <= next_ptr;
                            state_q     <= ST_IDLE;
                        end else begin
                            wd_q <= wd_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gcm_aes_arbiter.sv
// Self-checking bench for gcm_aes_arbiter against a round-robin reference model.
module tb_gcm_aes_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*128-1:0] req_block;
    logic [N-1:0]   ack;
    logic [127:0]   resp_data;
    logic [N-1:0]   resp_valid;
    logic           aes_ready;
    logic           aes_start;
    logic [127:0]   aes_block;
    logic [127:0]   aes_result;
    logic           aes_result_valid;
    logic           flush;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;

    logic [127:0]   blk [N];
    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    assign req_block = {blk[2], blk[1], blk[0]};

    always #5 clk = ~clk;

    gcm_aes_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_block        (req_block),
        .ack              (ack),
        .resp_data        (resp_data),
        .resp_valid       (resp_valid),
        .aes_ready        (aes_ready),
        .aes_start        (aes_start),
        .aes_block        (aes_block),
        .aes_result       (aes_result),
        .aes_result_valid (aes_result_valid),
        .flush            (flush),
        .busy             (busy),
        .grant_id         (grant_id),
        .timeout_err      (timeout_err)
    );

    // First requester at or after the pointer, wrapping; -1 when none.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int e);
        logic [N-1:0] v;
        v = '0;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_result(input logic [127:0] d);
        aes_result       = d;
        aes_result_valid = 1'b1;
        tick();
        aes_result_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 3'b111; flush = 1'b0; aes_ready = 1'b1;
        aes_result = '0; aes_result_valid = 1'b0;
        for (int i = 0; i < N; i++) blk[i] = rnd128();
        tick(); tick();
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp 000", ack); end
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL reset_resp_valid got %b exp 000", resp_valid); end
        checks++; if (resp_data !== 128'h0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL reset_aes_start got %b exp 0", aes_start); end
        checks++; if (aes_block !== 128'h0) begin errors++; $display("FAIL reset_aes_block got %h exp 0", aes_block); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
        req = 3'b000;
        tick();
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
    endtask

    task automatic test_single();
        logic [127:0] d;
        d = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
        blk[1] = 128'h1;
        req = 3'b010;
        #1;
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL single_ack got %b exp 010", ack); end
        tick();
        req = 3'b000;
        #1;
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", aes_start); end
        checks++; if (aes_block !== 128'h1) begin errors++; $display("FAIL single_block got %h exp 1", aes_block); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        repeat (10) tick();
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL single_early_resp got %b exp 000", resp_valid); end
        pulse_result(d);
        checks++; if (resp_valid !== 3'b010) begin errors++; $display("FAIL single_resp_valid got %b exp 010", resp_valid); end
        checks++; if (resp_data !== d) begin errors++; $display("FAIL single_resp_data got %h exp %h", resp_data, d); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id got %0d exp 1", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b exp 0", busy); end
        tick();
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL single_pulse_len got %b exp 000", resp_valid); end
        checks++; if (resp_data !== d) begin errors++; $display("FAIL single_data_hold got %h exp %h", resp_data, d); end
        m_ptr = 2;
    endtask

    task automatic test_round_robin();
        int e;
        int order [4] = '{0, 1, 2, 0};
        logic [127:0] d;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        m_ptr = 0;
        for (int i = 0; i < N; i++) blk[i] = rnd128();
        req = 3'b111;
        for (int j = 0; j < 4; j++) begin
            #1;
            e = model_pick(req, m_ptr);
            checks++; if (ack !== onehot(order[j])) begin errors++; $display("FAIL rr_ack job %0d got %b exp %b", j, ack, onehot(order[j])); end
            tick();
            checks++; if (aes_block !== blk[e]) begin errors++; $display("FAIL rr_block job %0d got %h exp %h", j, aes_block, blk[e]); end
            tick();
            repeat ($urandom_range(0, 5)) tick();
            d = rnd128();
            pulse_result(d);
            checks++; if (resp_valid !== onehot(e)) begin errors++; $display("FAIL rr_resp_valid job %0d got %b exp %b", j, resp_valid, onehot(e)); end
            checks++; if (resp_data !== d) begin errors++; $display("FAIL rr_resp_data job %0d got %h exp %h", j, resp_data, d); end
            m_ptr = (e + 1) % N;
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_not_ready();
        aes_ready = 1'b0;
        req = 3'b001;
        #1;
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL notready_ack got %b exp 000", ack); end
        tick();
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL notready_start got %b exp 0", aes_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL notready_busy got %b exp 0", busy); end
        tick();
        aes_ready = 1'b1;
        #1;
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL ready_ack got %b exp 001", ack); end
        tick();
        req = 3'b000;
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL ready_start got %b exp 1", aes_start); end
        tick();
        pulse_result(rnd128());
        checks++; if (resp_valid !== 3'b001) begin errors++; $display("FAIL ready_resp got %b exp 001", resp_valid); end
        m_ptr = 1;
    endtask

    task automatic test_timeout();
        req = 3'b100;
        #1;
        checks++; if (ack !== 3'b100) begin errors++; $display("FAIL to_ack got %b exp 100", ack); end
        tick();
        req = 3'b000;
        tick();
        for (int k = 1; k <= TO; k++) begin
            checks++;
            if (busy !== 1'b1 || timeout_err !== 1'b0 || resp_valid !== 3'b000) begin
                errors++;
                $display("FAIL to_wait cycle %0d got busy %b err %b rv %b exp 1 0 000", k, busy, timeout_err, resp_valid);
            end
            tick();
        end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got busy %b exp 0", busy); end
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL to_no_resp got %b exp 000", resp_valid); end
        m_ptr = 0;
        pulse_result(rnd128());
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL to_late_resp got %b exp 000", resp_valid); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_flush_clear got %b exp 0", timeout_err); end
    endtask

    task automatic test_flush_collision();
        int e;
        logic [127:0] d;
        req = 3'b111;
        #1;
        e = model_pick(req, m_ptr);
        checks++; if (ack !== onehot(e)) begin errors++; $display("FAIL fc_ack got %b exp %b", ack, onehot(e)); end
        tick();
        req = 3'b000;
        tick(); tick(); tick();
        flush = 1'b1;
        pulse_result(rnd128());
        flush = 1'b0;
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL fc_resp got %b exp 000", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fc_idle got busy %b exp 0", busy); end
        tick();
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL fc_resp_late got %b exp 000", resp_valid); end
        req = 3'b111;
        #1;
        e = model_pick(req, m_ptr);
        checks++; if (ack !== onehot(e)) begin errors++; $display("FAIL fc_next_ack got %b exp %b", ack, onehot(e)); end
        tick();
        req = 3'b000;
        tick();
        d = rnd128();
        pulse_result(d);
        checks++; if (resp_valid !== onehot(e) || resp_data !== d) begin errors++; $display("FAIL fc_next_resp got %b %h exp %b %h", resp_valid, resp_data, onehot(e), d); end
        m_ptr = (e + 1) % N;
    endtask

    task automatic test_random();
        int e;
        logic [N-1:0] r;
        logic [127:0] d;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) blk[i] = rnd128();
            r = N'($urandom_range(0, 7));
            aes_ready = ($urandom_range(0, 3) != 0);
            req = r;
            #1;
            e = (aes_ready && r != '0) ? model_pick(r, m_ptr) : -1;
            checks++; if (ack !== onehot(e)) begin errors++; $display("FAIL rnd_ack it %0d got %b exp %b", it, ack, onehot(e)); end
            tick();
            if (e < 0) begin
                checks++; if (aes_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_nogrant it %0d got start %b busy %b exp 0 0", it, aes_start, busy); end
                continue;
            end
            if ($urandom_range(0, 1) == 1) req = '0;
            checks++; if (aes_start !== 1'b1 || aes_block !== blk[e]) begin errors++; $display("FAIL rnd_issue it %0d got %b %h exp 1 %h", it, aes_start, aes_block, blk[e]); end
            tick();
            repeat ($urandom_range(0, TO - 2)) tick();
            d = rnd128();
            pulse_result(d);
            checks++;
            if (resp_valid !== onehot(e) || resp_data !== d || grant_id !== 2'(e)) begin
                errors++;
                $display("FAIL rnd_resp it %0d got %b %h id %0d exp %b %h id %0d", it, resp_valid, resp_data, grant_id, onehot(e), d, e);
            end
            m_ptr = (e + 1) % N;
        end
        req = '0;
        aes_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int e;
        req = 3'b011;
        #1;
        e = model_pick(req, m_ptr);
        checks++; if (ack !== onehot(e)) begin errors++; $display("FAIL rmw_ack got %b exp %b", ack, onehot(e)); end
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || aes_block !== '0 || grant_id !== 2'd0 || ack !== '0 || resp_data !== '0 || aes_start !== 1'b0) begin
            errors++;
            $display("FAIL rmw_outputs got busy %b blk %h id %0d ack %b data %h start %b exp all zero", busy, aes_block, grant_id, ack, resp_data, aes_start);
        end
        tick();
        req = 3'b000;
        rst_n = 1'b1;
        m_ptr = 0;
        pulse_result(rnd128());
        checks++; if (resp_valid !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rmw_stale got rv %b busy %b exp 000 0", resp_valid, busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit got running exp finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_not_ready();
        test_timeout();
        test_flush_collision();
        test_random();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
